// File: rtl/cpu_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arb_pkg
// Description : Shared constants and types for the CPU iBus/dBus memory
//               arbiter: source encoding, access sizes, grant-lock states.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_arb_pkg;

    // Source tag stored in the pending-read FIFO
    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    // Access size encoding shared by dBus and the memory port
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Grant lock: IDLE re-arbitrates, GNT_x holds a stalled command
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } gnt_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter_if
// Description : Bundles the iBus, dBus and merged memory-port signals.
//               'master' is the arbiter's view (it drives the memory port and
//               answers the CPU buses); 'slave' is the CPU/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mem_arbiter_if;

    logic        iBus_cmd_valid;
    logic        iBus_cmd_ready;
    logic [31:0] iBus_cmd_payload_pc;
    logic        iBus_rsp_valid;
    logic        iBus_rsp_payload_error;
    logic [31:0] iBus_rsp_payload_inst;

    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr;
    logic [31:0] dBus_cmd_payload_address;
    logic [31:0] dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready;
    logic        dBus_rsp_error;
    logic [31:0] dBus_rsp_data;

    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_wr;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_data;
    logic [1:0]  mem_cmd_size;
    logic        mem_rsp_valid;
    logic        mem_rsp_error;
    logic [31:0] mem_rsp_data;

    modport master (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        input  dBus_cmd_payload_data, dBus_cmd_payload_size,
        output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_data, mem_cmd_size,
        input  mem_cmd_ready, mem_rsp_valid, mem_rsp_error, mem_rsp_data
    );

    modport slave (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        output dBus_cmd_payload_data, dBus_cmd_payload_size,
        input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_data, mem_cmd_size,
        output mem_cmd_ready, mem_rsp_valid, mem_rsp_error, mem_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/cpu_mem_arb_pend_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arb_pend_fifo
// Description : 1-bit-wide in-order FIFO recording which bus issued each
//               outstanding read. DEPTH must be a power of two so the
//               pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arb_pend_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             din,
    output logic                  dout,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             w_push;
    logic             w_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next-state of storage, pointers and occupancy; overflow/underflow ignored
    always_comb begin
        w_push   = push && !full;
        w_pop    = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_arbiter
// Description : Merges the VexRiscv iBus and dBus onto one memory port.
//               Combinational command and response paths; the grant is held
//               while a command stalls; a pending FIFO routes read responses.
//               Optional macro CPU_MEM_ARB_RR_EN selects round-robin
//               arbitration instead of fixed dBus-over-iBus priority.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter  int MAX_PENDING = 4,
    localparam int PEND_W      = $clog2(MAX_PENDING) + 1
) (
    input  wire logic          clk_cpu,
    input  wire logic          clk_cpu_reset,
    cpu_mem_arbiter_if.master  bus,
    output logic [PEND_W-1:0]  pending_cnt,
    output logic               rsp_orphan
);

    gnt_state_e state_q, state_d;
    logic       orphan_q, orphan_d;
    logic       w_gnt;
    logic       w_gnt_valid;
    logic       w_gnt_rd;
    logic       w_blocked;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic       w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_rsp_hit;

`ifdef CPU_MEM_ARB_RR_EN
    logic       last_q, last_d;
`endif

    // Grant for this cycle: locked bus if stalled, otherwise arbitrate
    always_comb begin
        w_gnt = SRC_I;
        case (state_q)
            GNT_I:   w_gnt = SRC_I;
            GNT_D:   w_gnt = SRC_D;
            default: begin
                if (bus.dBus_cmd_valid && bus.iBus_cmd_valid) begin
`ifdef CPU_MEM_ARB_RR_EN
                    w_gnt = (last_q == SRC_I) ? SRC_D : SRC_I;
`else
                    w_gnt = SRC_D;
`endif
                end else if (bus.dBus_cmd_valid) begin
                    w_gnt = SRC_D;
                end
            end
        endcase
    end

    // Merged command, handshake and blocking on a full pending FIFO
    always_comb begin
        w_gnt_valid = (w_gnt == SRC_D) ? bus.dBus_cmd_valid : bus.iBus_cmd_valid;
        w_gnt_rd    = (w_gnt == SRC_D) ? !bus.dBus_cmd_payload_wr : 1'b1;
        w_blocked   = w_full && w_gnt_rd;

        bus.mem_cmd_valid  = !clk_cpu_reset && w_gnt_valid && !w_blocked;
        bus.dBus_cmd_ready = !clk_cpu_reset && (w_gnt == SRC_D) && bus.mem_cmd_ready && !w_blocked;
        bus.iBus_cmd_ready = !clk_cpu_reset && (w_gnt == SRC_I) && bus.mem_cmd_ready && !w_blocked;

        if (w_gnt == SRC_D) begin
            bus.mem_cmd_wr   = bus.dBus_cmd_payload_wr;
            bus.mem_cmd_addr = bus.dBus_cmd_payload_address;
            bus.mem_cmd_data = bus.dBus_cmd_payload_data;
            bus.mem_cmd_size = bus.dBus_cmd_payload_size;
        end else begin
            bus.mem_cmd_wr   = 1'b0;
            bus.mem_cmd_addr = bus.iBus_cmd_payload_pc;
            bus.mem_cmd_data = 32'd0;
            bus.mem_cmd_size = SZ_WORD;
        end

        w_accept = bus.mem_cmd_valid && bus.mem_cmd_ready;
        w_push   = w_accept && w_gnt_rd;
    end

    // Lock the grant while the granted command is presented but not taken
    always_comb begin
        state_d = IDLE;
        if (w_gnt_valid && !w_accept) begin
            state_d = (w_gnt == SRC_D) ? GNT_D : GNT_I;
        end
`ifdef CPU_MEM_ARB_RR_EN
        last_d = w_accept ? w_gnt : last_q;
`endif
    end

    // Response routing by FIFO head; orphans are dropped and flagged
    always_comb begin
        w_rsp_hit = !clk_cpu_reset && bus.mem_rsp_valid && !w_empty;
        w_pop     = bus.mem_rsp_valid && !w_empty;
        orphan_d  = orphan_q || (bus.mem_rsp_valid && w_empty);

        bus.iBus_rsp_valid         = w_rsp_hit && (w_head == SRC_I);
        bus.iBus_rsp_payload_error = w_rsp_hit && (w_head == SRC_I) && bus.mem_rsp_error;
        bus.iBus_rsp_payload_inst  = bus.mem_rsp_data;
        bus.dBus_rsp_ready         = w_rsp_hit && (w_head == SRC_D);
        bus.dBus_rsp_error         = w_rsp_hit && (w_head == SRC_D) && bus.mem_rsp_error;
        bus.dBus_rsp_data          = bus.mem_rsp_data;
    end

    // Grant lock, orphan flag and last-winner registers
    always_ff @(posedge clk_cpu) begin
        if (clk_cpu_reset) begin
            state_q  <= IDLE;
            orphan_q <= 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
            last_q   <= SRC_I;
`endif
        end else begin
            state_q  <= state_d;
            orphan_q <= orphan_d;
`ifdef CPU_MEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign rsp_orphan = orphan_q;

    cpu_mem_arb_pend_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_pend_fifo (
        .clk   (clk_cpu),
        .rst   (clk_cpu_reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_gnt),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (pending_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_arbiter
// Description : Directed self-checking bench for cpu_mem_arbiter. A queue
//               model of the pending reads and grant rules is compared
//               against the DUT every cycle; literal checks pin key cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

    localparam int MAXP = 4;
    localparam int PW   = $clog2(MAXP) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pending_cnt;
    logic          rsp_orphan;
    int            checks = 0;
    int            passes = 0;

    cpu_mem_arbiter_if bus();

    cpu_mem_arbiter #(
        .MAX_PENDING (MAXP)
    ) dut (
        .clk_cpu       (clk),
        .clk_cpu_reset (rst),
        .bus           (bus),
        .pending_cnt   (pending_cnt),
        .rsp_orphan    (rsp_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- model: pending reads, lock, last winner, orphan ------
    bit   mq[$];          // 0 = iBus, 1 = dBus, oldest first
    int   m_lock = 0;     // 0 none, 1 iBus, 2 dBus
    bit   m_orph = 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
    bit   m_last = 1'b0;
`endif
    logic m_g, m_gv, m_rd, m_blk, m_acc, m_hi, m_hd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_valid", 32'(bus.mem_cmd_valid), 32'd0);
            chk("rst_i_ready",   32'(bus.iBus_cmd_ready), 32'd0);
            chk("rst_d_ready",   32'(bus.dBus_cmd_ready), 32'd0);
            chk("rst_i_rsp",     32'(bus.iBus_rsp_valid), 32'd0);
            chk("rst_i_err",     32'(bus.iBus_rsp_payload_error), 32'd0);
            chk("rst_d_rsp",     32'(bus.dBus_rsp_ready), 32'd0);
            chk("rst_d_err",     32'(bus.dBus_rsp_error), 32'd0);
            mq.delete();
            m_lock = 0;
            m_orph = 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
            m_last = 1'b0;
`endif
        end else begin
            if (m_lock == 1) m_g = 1'b0;
            else if (m_lock == 2) m_g = 1'b1;
            else if (bus.dBus_cmd_valid && bus.iBus_cmd_valid) begin
`ifdef CPU_MEM_ARB_RR_EN
                m_g = ~m_last;
`else
                m_g = 1'b1;
`endif
            end else m_g = bus.dBus_cmd_valid;
            m_gv  = m_g ? bus.dBus_cmd_valid : bus.iBus_cmd_valid;
            m_rd  = m_g ? ~bus.dBus_cmd_payload_wr : 1'b1;
            m_blk = m_rd && (mq.size() == MAXP);
            m_acc = m_gv && !m_blk && bus.mem_cmd_ready;

            chk("m_cmd_valid", 32'(bus.mem_cmd_valid), 32'(m_gv && !m_blk));
            if (m_gv && !m_blk) begin
                chk("m_cmd_wr",   32'(bus.mem_cmd_wr),   32'(m_g ? bus.dBus_cmd_payload_wr : 1'b0));
                chk("m_cmd_addr", bus.mem_cmd_addr, m_g ? bus.dBus_cmd_payload_address : bus.iBus_cmd_payload_pc);
                chk("m_cmd_data", bus.mem_cmd_data, m_g ? bus.dBus_cmd_payload_data : 32'd0);
                chk("m_cmd_size", 32'(bus.mem_cmd_size), m_g ? 32'(bus.dBus_cmd_payload_size) : 32'd2);
            end
            if (bus.iBus_cmd_valid || bus.dBus_cmd_valid) begin
                chk("m_i_ready", 32'(bus.iBus_cmd_ready), 32'(!m_g && bus.mem_cmd_ready && !m_blk));
                chk("m_d_ready", 32'(bus.dBus_cmd_ready), 32'(m_g && bus.mem_cmd_ready && !m_blk));
            end

            m_hi = bus.mem_rsp_valid && (mq.size() > 0) && (mq[0] == 1'b0);
            m_hd = bus.mem_rsp_valid && (mq.size() > 0) && (mq[0] == 1'b1);
            chk("m_i_rsp", 32'(bus.iBus_rsp_valid), 32'(m_hi));
            chk("m_d_rsp", 32'(bus.dBus_rsp_ready), 32'(m_hd));
            if (m_hi) begin
                chk("m_i_inst", bus.iBus_rsp_payload_inst, bus.mem_rsp_data);
                chk("m_i_err",  32'(bus.iBus_rsp_payload_error), 32'(bus.mem_rsp_error));
            end
            if (m_hd) begin
                chk("m_d_data", bus.dBus_rsp_data, bus.mem_rsp_data);
                chk("m_d_err",  32'(bus.dBus_rsp_error), 32'(bus.mem_rsp_error));
            end
            chk("m_pending", 32'(pending_cnt), 32'(mq.size()));
            chk("m_orphan",  32'(rsp_orphan), 32'(m_orph));

            if (bus.mem_rsp_valid) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_orph = 1'b1;
            end
            if (m_acc && m_rd) mq.push_back(m_g);
`ifdef CPU_MEM_ARB_RR_EN
            if (m_acc) m_last = m_g;
`endif
            m_lock = (m_gv && !m_acc) ? (m_g ? 2 : 1) : 0;
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic half(); @(negedge clk); #1; endtask
    task automatic step(); @(posedge clk); #1; endtask

    task automatic ireq(input logic v, input logic [31:0] pc);
        bus.iBus_cmd_valid      = v;
        bus.iBus_cmd_payload_pc = pc;
    endtask

    task automatic dreq(input logic v, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
        bus.dBus_cmd_valid           = v;
        bus.dBus_cmd_payload_wr      = wr;
        bus.dBus_cmd_payload_address = a;
        bus.dBus_cmd_payload_data    = d;
        bus.dBus_cmd_payload_size    = sz;
    endtask

    task automatic mrsp(input logic v, input logic e, input logic [31:0] d);
        bus.mem_rsp_valid = v;
        bus.mem_rsp_error = e;
        bus.mem_rsp_data  = d;
    endtask

    bit arb_pat [4];
    int n_drain;

    initial begin
        ireq(1'b1, 32'h100);
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        mrsp(1'b0, 1'b0, 32'd0);
        bus.mem_cmd_ready = 1'b1;

        // Reset holds every handshake low even with a request present
        half();
        chk("rst_cmd_valid", 32'(bus.mem_cmd_valid), 32'd0);
        chk("rst_iready",    32'(bus.iBus_cmd_ready), 32'd0);
        step(); step();
        rst = 1'b0;
        ireq(1'b0, 32'd0);
        half();
        chk("reset_pending", 32'(pending_cnt), 32'd0);
        chk("reset_orphan",  32'(rsp_orphan), 32'd0);
        step();

        // Lone fetch, response two cycles later
        ireq(1'b1, 32'h100);
        half();
        chk("fetch_valid", 32'(bus.mem_cmd_valid), 32'd1);
        chk("fetch_addr",  bus.mem_cmd_addr, 32'h100);
        chk("fetch_size",  32'(bus.mem_cmd_size), 32'd2);
        chk("fetch_wr",    32'(bus.mem_cmd_wr), 32'd0);
        step();
        ireq(1'b0, 32'd0);
        step();
        mrsp(1'b1, 1'b0, 32'hDEADBEEF);
        half();
        chk("fetch_rsp_valid", 32'(bus.iBus_rsp_valid), 32'd1);
        chk("fetch_rsp_inst",  bus.iBus_rsp_payload_inst, 32'hDEADBEEF);
        chk("fetch_rsp_dbus",  32'(bus.dBus_rsp_ready), 32'd0);
        step();
        mrsp(1'b0, 1'b0, 32'd0);

        // Both request while memory stalls: dBus holds the grant
        bus.mem_cmd_ready = 1'b0;
        ireq(1'b1, 32'h200);
        dreq(1'b1, 1'b0, 32'h40, 32'd0, 2'd2);
        for (int k = 0; k < 3; k++) begin
            half();
            chk("stall_addr",   bus.mem_cmd_addr, 32'h40);
            chk("stall_iready", 32'(bus.iBus_cmd_ready), 32'd0);
            step();
        end
        bus.mem_cmd_ready = 1'b1;
        half();
        chk("stall_dready", 32'(bus.dBus_cmd_ready), 32'd1);
        step();
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        half();
        chk("next_iready", 32'(bus.iBus_cmd_ready), 32'd1);
        chk("next_addr",   bus.mem_cmd_addr, 32'h200);
        step();
        ireq(1'b0, 32'd0);
        mrsp(1'b1, 1'b0, 32'h1111);
        half();
        chk("order_d_first", 32'(bus.dBus_rsp_ready), 32'd1);
        step();
        mrsp(1'b1, 1'b0, 32'h2222);
        half();
        chk("order_i_second", 32'(bus.iBus_rsp_valid), 32'd1);
        step();
        mrsp(1'b0, 1'b0, 32'd0);

        // Continuous dual requests: iBus reads, dBus writes
`ifdef CPU_MEM_ARB_RR_EN
        arb_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        arb_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        ireq(1'b1, 32'h400);
        dreq(1'b1, 1'b1, 32'h44, 32'hCAFE, 2'd2);
        for (int k = 0; k < 4; k++) begin
            half();
            chk("arb_seq_d", 32'(bus.dBus_cmd_ready), 32'(arb_pat[k]));
            chk("arb_seq_i", 32'(bus.iBus_cmd_ready), 32'(!arb_pat[k]));
            step();
        end
        ireq(1'b0, 32'd0);
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        n_drain = mq.size();
        for (int k = 0; k < n_drain; k++) begin
            mrsp(1'b1, 1'b0, 32'h5555 + k);
            step();
        end
        mrsp(1'b0, 1'b0, 32'd0);

        // Lock holds iBus even after dBus raises valid
        bus.mem_cmd_ready = 1'b0;
        ireq(1'b1, 32'h300);
        step();
        dreq(1'b1, 1'b1, 32'h80, 32'h77, 2'd2);
        half();
        chk("lock_addr",   bus.mem_cmd_addr, 32'h300);
        chk("lock_dready", 32'(bus.dBus_cmd_ready), 32'd0);
        step();
        bus.mem_cmd_ready = 1'b1;
        half();
        chk("lock_iready", 32'(bus.iBus_cmd_ready), 32'd1);
        step();
        ireq(1'b0, 32'd0);
        half();
        chk("unlock_dready", 32'(bus.dBus_cmd_ready), 32'd1);
        step();
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        mrsp(1'b1, 1'b0, 32'h3333);
        step();
        mrsp(1'b0, 1'b0, 32'd0);

        // Fill the FIFO with reads I, D, I, D
        ireq(1'b1, 32'h10); step();
        ireq(1'b0, 32'd0); dreq(1'b1, 1'b0, 32'h14, 32'd0, 2'd2); step();
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0); ireq(1'b1, 32'h18); step();
        ireq(1'b0, 32'd0); dreq(1'b1, 1'b0, 32'h1C, 32'd0, 2'd2); step();
        dreq(1'b1, 1'b1, 32'h3000, 32'hABCD, 2'd2);
        half();
        chk("full_pending",  32'(pending_cnt), 32'd4);
        chk("full_wr_ready", 32'(bus.dBus_cmd_ready), 32'd1);
        chk("full_wr_valid", 32'(bus.mem_cmd_valid), 32'd1);
        step();
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        ireq(1'b1, 32'h500);
        half();
        chk("blk_valid",   32'(bus.mem_cmd_valid), 32'd0);
        chk("blk_iready",  32'(bus.iBus_cmd_ready), 32'd0);
        chk("blk_pending", 32'(pending_cnt), 32'd4);
        step();
        mrsp(1'b1, 1'b0, 32'hA0);
        half();
        chk("drain0_i",       32'(bus.iBus_rsp_valid), 32'd1);
        chk("drain0_inst",    bus.iBus_rsp_payload_inst, 32'hA0);
        chk("pop_no_unblock", 32'(bus.mem_cmd_valid), 32'd0);
        step();
        mrsp(1'b1, 1'b1, 32'hA1);
        half();
        chk("unblocked",  32'(bus.mem_cmd_valid), 32'd1);
        chk("drain1_d",   32'(bus.dBus_rsp_ready), 32'd1);
        chk("drain1_err", 32'(bus.dBus_rsp_error), 32'd1);
        step();
        ireq(1'b0, 32'd0);
        mrsp(1'b1, 1'b0, 32'hA2);
        half();
        chk("pushpop_cnt", 32'(pending_cnt), 32'd3);
        chk("drain2_i",    32'(bus.iBus_rsp_valid), 32'd1);
        step();
        mrsp(1'b1, 1'b0, 32'hA3);
        half();
        chk("drain3_d", 32'(bus.dBus_rsp_ready), 32'd1);
        step();
        mrsp(1'b1, 1'b0, 32'hA4);
        half();
        chk("drain4_i", 32'(bus.iBus_rsp_valid), 32'd1);
        step();
        mrsp(1'b0, 1'b0, 32'd0);
        half();
        chk("drained", 32'(pending_cnt), 32'd0);
        step();

        // Write produces no pending entry; a stray response is an orphan
        dreq(1'b1, 1'b1, 32'h2000, 32'h12345678, 2'd2);
        half();
        chk("wr_flag", 32'(bus.mem_cmd_wr), 32'd1);
        chk("wr_addr", bus.mem_cmd_addr, 32'h2000);
        chk("wr_data", bus.mem_cmd_data, 32'h12345678);
        chk("wr_size", 32'(bus.mem_cmd_size), 32'd2);
        step();
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        half();
        chk("wr_pending", 32'(pending_cnt), 32'd0);
        step();
        mrsp(1'b1, 1'b0, 32'h9999);
        half();
        chk("orph_i", 32'(bus.iBus_rsp_valid), 32'd0);
        chk("orph_d", 32'(bus.dBus_rsp_ready), 32'd0);
        step();
        mrsp(1'b0, 1'b0, 32'd0);
        half();
        chk("orph_set", 32'(rsp_orphan), 32'd1);
        step();

        // Reset with two reads outstanding
        ireq(1'b1, 32'h600); step();
        ireq(1'b0, 32'd0); dreq(1'b1, 1'b0, 32'h700, 32'd0, 2'd2); step();
        dreq(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
        half();
        chk("pre_rst_pending", 32'(pending_cnt), 32'd2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        half();
        chk("post_rst_pending", 32'(pending_cnt), 32'd0);
        chk("post_rst_orphan",  32'(rsp_orphan), 32'd0);
        step();
        mrsp(1'b1, 1'b0, 32'h8888);
        half();
        chk("late_i", 32'(bus.iBus_rsp_valid), 32'd0);
        chk("late_d", 32'(bus.dBus_rsp_ready), 32'd0);
        step();
        mrsp(1'b1, 1'b0, 32'h8889);
        step();
        mrsp(1'b0, 1'b0, 32'd0);
        half();
        chk("late_orphan", 32'(rsp_orphan), 32'd1);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one memory port between the VexRiscv iBus and dBus (simple-bus flavour).
- Sits between the CPU core and the single-port memory/peripheral fabric, so both buses reach one RAM without a dual-port memory.
- Arbitrates commands, locks the grant while a command is stalled, and records the source of every read in an in-order pending FIFO.
- Uses that FIFO to route each memory response back to the requester that issued the read.

Parameters:
- MAX_PENDING, 4: maximum outstanding reads on mem bus; power of 2, range 2..16.
- PEND_W, $clog2(MAX_PENDING)+1: width of pending count; derived, not overridden.

Ports:
- clk_cpu  in  1  sole clock.
- clk_cpu_reset  in  1  reset, synchronous, active-high.
- iBus_cmd_valid  in  1  fetch request.
- iBus_cmd_ready  out  1  fetch accepted.
- iBus_cmd_payload_pc  in  32  fetch address.
- iBus_rsp_valid  out  1  fetch data valid.
- iBus_rsp_payload_error  out  1  fetch bus error.
- iBus_rsp_payload_inst  out  32  fetched word.
- dBus_cmd_valid  in  1  data request.
- dBus_cmd_ready  out  1  data request accepted.
- dBus_cmd_payload_wr  in  1  1 = write.
- dBus_cmd_payload_address  in  32  data address.
- dBus_cmd_payload_data  in  32  write data.
- dBus_cmd_payload_size  in  2  0 = byte, 1 = half, 2 = word.
- dBus_rsp_ready  out  1  read data valid.
- dBus_rsp_error  out  1  read bus error.
- dBus_rsp_data  out  32  read data.
- mem_cmd_valid  out  1  merged command valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_wr  out  1  merged write flag.
- mem_cmd_addr  out  32  merged address.
- mem_cmd_data  out  32  merged write data.
- mem_cmd_size  out  2  merged size.
- mem_rsp_valid  in  1  read response valid.
- mem_rsp_error  in  1  read response error.
- mem_rsp_data  in  32  read response data.
- pending_cnt  out  PEND_W  outstanding reads.
- rsp_orphan  out  1  sticky: response arrived with no pending read.

Behaviour:
- Reset values:
  - grant state IDLE.
  - FIFO empty; pending_cnt = 0.
  - rsp_orphan = 0.
  - RR last-winner = I.
  - All *_valid, *_ready, error outputs = 0 while clk_cpu_reset is high.
- State machine, states IDLE, GNT_I, GNT_D. The registered state is the grant lock; the grant for the current cycle is computed combinationally.
  - IDLE, or any state after a completed accept: choose a winner among the valid requests (fixed priority: dBus over iBus).
  - If the winner's command is presented but not accepted (mem_cmd_ready = 0, or blocked as below), the state moves to GNT_x and stays there until that command is accepted, even if the other bus raises valid.
  - On accept with no new request, return to IDLE.
- Command path is combinational, zero latency:
  - mem_cmd_valid = granted valid AND NOT blocked.
  - Granted bus ready = mem_cmd_ready AND NOT blocked; the non-granted bus ready = 0.
- Command mapping:
  - iBus: wr = 0, addr = pc, data = 0, size = 2'b10.
  - dBus: fields pass through unchanged.
- Accept = mem_cmd_valid AND mem_cmd_ready.
- Pending FIFO:
  - Depth MAX_PENDING, 1-bit entries, 0 = I, 1 = D.
  - Push on accept of a read. Writes are never pushed and produce no response.
  - Pop on mem_rsp_valid.
- blocked = FIFO full AND granted command is a read.
  - Blocking is based on the current full flag only; a same-cycle pop does not unblock.
  - Writes are never blocked.
- Response routing is combinational, zero latency. With the FIFO non-empty, the head selects the destination:
  - Selected bus gets rsp valid, error and data.
  - Other bus gets valid = 0; its data output = mem_rsp_data (don't care).
- Orphan response: mem_rsp_valid with the FIFO empty.
  - Not forwarded to either bus; no pop.
  - rsp_orphan set to 1, cleared only by reset.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Pointer wrap: modulo MAX_PENDING.
- Reset mid-operation: FIFO cleared. Responses for pre-reset reads then arrive as orphans; this is the intended behaviour.
- pending_cnt: +1 on push, -1 on pop, net 0 on both.

Optional Feature:
- Macro: CPU_MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both buses request in an unlocked cycle, the bus that did not win the most recent accept is granted.
  - Last-winner updates on every accept.
- Undefined: fixed priority, dBus over iBus; the last-winner register is not built.

Decomposition:
- Package cpu_mem_arb_pkg:
  - Source encoding constants SRC_I = 0, SRC_D = 1.
  - Size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - Grant state enum {IDLE, GNT_I, GNT_D}.
- Sub-module cpu_mem_arb_pend_fifo:
  - 1-bit-wide FIFO, depth MAX_PENDING.
  - Interface: push, pop, din, dout, full, empty, count.
- Arbitration and routing stay in the top module.

Test Plan:
- Lone iBus fetch at pc 0x100, mem_cmd_ready = 1:
  - Same cycle: mem_cmd_addr = 0x100, size = 2, wr = 0.
  - Response 0xDEADBEEF two cycles later: iBus_rsp_valid = 1 with inst 0xDEADBEEF; dBus_rsp_ready = 0.
- Both buses valid, mem_cmd_ready = 0 for 3 cycles, then 1:
  - dBus granted throughout; iBus_cmd_ready stays 0.
  - iBus granted on the next cycle.
  - With CPU_MEM_ARB_RR_EN: continuous dual requests alternate D, I, D, I.
- Four reads accepted (order I, D, I, D) with no responses, MAX_PENDING = 4:
  - Fifth read is blocked: mem_cmd_valid = 0, pending_cnt = 4.
  - A dBus write in the same state is still accepted.
  - Responses are returned to I, D, I, D in order.
- dBus write 0x12345678 to 0x2000, size 2:
  - pending_cnt unchanged.
  - A subsequent mem_rsp_valid sets rsp_orphan = 1 and no rsp valid is asserted.
- Reset asserted with 2 reads pending:
  - pending_cnt = 0 on the next cycle.
  - Late responses set rsp_orphan.
  - Neither bus sees a valid response.
